w_seq_divider: RTL and testbench

Iterative signed integer divider, the inverse of the team's signed multiplier: takes an M-bit signed dividend and N-bit signed divisor, returns an (M+1)-bit signed quotient and N-bit signed remainder. It uses one restoring-division step per clock with a start/done handshake. It sits beside the multiplier in the arithmetic building-block library and serves datapaths that can tolerate multi-cycle latency in exchange for small area.

---
 rtl/w_seq_divider_pkg.sv | 14 +
 rtl/w_seq_divider_if.sv | 17 +
 rtl/w_seq_divider_step.sv | 21 ++
 rtl/w_seq_divider.sv | 158 +++++++++++++++
 tb/tb_w_seq_divider.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/w_seq_divider_pkg.sv
// Shared types and helpers for the iterative signed divider.
package w_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/w_seq_divider_if.sv
// Request/result bundle between a client and the iterative signed divider.
interface w_seq_divider_if #(
  parameter int unsigned M = 8,
  parameter int unsigned N = 8
);
  logic         START;
  logic [M-1:0] A;
  logic [N-1:0] B;
  logic [M:0]   Q;
  logic [N-1:0] R;
  logic         BUSY;
  logic         DONE;
  logic         DIV0;

  modport master (output START, A, B, input Q, R, BUSY, DONE, DIV0);
  modport slave  (input START, A, B, output Q, R, BUSY, DONE, DIV0);
endinterface

// File: rtl/w_seq_divider_step.sv
// One restoring-division step on unsigned magnitudes: shift in a dividend bit, trial-subtract.
module w_div_step #(
  parameter int unsigned N = 8
) (
  input  logic [N:0]   rem_i,
  input  logic         bit_i,
  input  logic [N-1:0] dvsr_i,
  output logic [N:0]   rem_o,
  output logic         q_o
);
  logic [N:0]   shifted;
  logic [N+1:0] diff;

  always_comb begin
    shifted = {rem_i[N-1:0], bit_i};
    diff    = {1'b0, shifted} - {2'b00, dvsr_i};
    // A set top bit means the shifted value exceeds any N-bit divisor.
    q_o     = rem_i[N] | ~diff[N+1];
    rem_o   = q_o ? diff[N:0] : shifted;
  end
endmodule

// File: rtl/w_seq_divider.sv
// Iterative signed divider, one restoring step per clock, start/done handshake.
// Optional zero-divisor shortcut and flag: define W_SEQ_DIVIDER_DIV0_EN.
module w_seq_divider
  import w_div_pkg::*;
#(
  parameter int unsigned M = 8,
  parameter int unsigned N = 8
) (
  input logic             CLK,
  input logic             RST,
  w_seq_divider_if.slave  bus
);
  localparam int unsigned CW = cnt_width(M);
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  state_t        state_q, state_d;
  logic [M-1:0]  dvd_q, dvd_d;      // dividend bits shift out MSB-first, quotient bits shift in
  logic [N-1:0]  bmag_q, bmag_d;
  logic [N:0]    rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          aneg_q, aneg_d;
  logic          qneg_q, qneg_d;
  logic [M:0]    q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic          done_q, done_d;
  logic [N:0]    step_rem;
  logic          step_q;
  logic          b_zero;
  logic [M:0]    q_mag;
`ifdef W_SEQ_DIVIDER_DIV0_EN
  logic          zero_q, zero_d;
  logic          div0_q, div0_d;
`endif

  w_div_step #(.N(N)) u_step (
    .rem_i  (rem_q),
    .bit_i  (dvd_q[M-1]),
    .dvsr_i (bmag_q),
    .rem_o  (step_rem),
    .q_o    (step_q)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      bmag_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      aneg_q  <= 1'b0;
      qneg_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
`ifdef W_SEQ_DIVIDER_DIV0_EN
      zero_q  <= 1'b0;
      div0_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      bmag_q  <= bmag_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      aneg_q  <= aneg_d;
      qneg_q  <= qneg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
`ifdef W_SEQ_DIVIDER_DIV0_EN
      zero_q  <= zero_d;
      div0_q  <= div0_d;
`endif
    end
  end

  assign b_zero = (bus.B == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
`ifdef W_SEQ_DIVIDER_DIV0_EN
          state_d = b_zero ? FIX : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC:    if (cnt_q == LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dvd_d  = dvd_q;
    bmag_d = bmag_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    aneg_d = aneg_q;
    qneg_d = qneg_q;
    q_d    = q_q;
    r_d    = r_q;
    done_d = 1'b0;
    q_mag  = {1'b0, dvd_q};
`ifdef W_SEQ_DIVIDER_DIV0_EN
    zero_d = zero_q;
    div0_d = div0_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          // M-bit negation read as unsigned keeps -2^(M-1) exact.
          dvd_d  = bus.A[M-1] ? -bus.A : bus.A;
          bmag_d = bus.B[N-1] ? -bus.B : bus.B;
          aneg_d = bus.A[M-1];
          qneg_d = bus.A[M-1] ^ bus.B[N-1];
          rem_d  = '0;
          cnt_d  = '0;
`ifdef W_SEQ_DIVIDER_DIV0_EN
          zero_d = b_zero;
`endif
        end
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[M-2:0], step_q};
        cnt_d = cnt_q + CW'(1);
      end
      FIX: begin
        done_d = 1'b1;
        q_d    = qneg_q ? -q_mag : q_mag;
        r_d    = aneg_q ? -rem_q[N-1:0] : rem_q[N-1:0];
`ifdef W_SEQ_DIVIDER_DIV0_EN
        div0_d = zero_q;
        if (zero_q) begin
          q_d = '0;
          r_d = '0;
        end
`endif
      end
      default: ;
    endcase
  end

  assign bus.Q    = q_q;
  assign bus.R    = r_q;
  assign bus.BUSY = (state_q != IDLE);
  assign bus.DONE = done_q;
`ifdef W_SEQ_DIVIDER_DIV0_EN
  assign bus.DIV0 = div0_q;
`else
  assign bus.DIV0 = 1'b0;
`endif

endmodule

// File: tb/tb_w_seq_divider.sv
// Directed self-checking bench for w_seq_divider with hand-computed quotients/remainders.
module tb_w_seq_divider;
  localparam int unsigned M = 8;
  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  w_seq_divider_if #(.M(M), .N(N)) bus ();

  w_seq_divider #(.M(M), .N(N)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int q_val();
    return int'($signed(bus.Q));
  endfunction

  function automatic int r_val();
    return int'($signed(bus.R));
  endfunction

  // Called 1 time unit after an edge; returns 1 time unit after the accepting edge.
  task automatic start_op(input int a, input int b);
    bus.A     = M'(a);
    bus.B     = N'(b);
    bus.START = 1'b1;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_ok);
    lat     = 0;
    busy_ok = 1;
    while (bus.DONE !== 1'b1 && lat < 40) begin
      if (bus.BUSY !== 1'b1) busy_ok = 0;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input int a, input int b, input int eq, input int er);
    int lat;
    int busy_ok;
    start_op(a, b);
    wait_done(lat, busy_ok);
    check({tag, "_lat"}, lat, M + 1);
    check({tag, "_busy"}, busy_ok, 1);
    check({tag, "_busy_end"}, int'(bus.BUSY), 0);
    check({tag, "_q"}, q_val(), eq);
    check({tag, "_r"}, r_val(), er);
    check({tag, "_div0"}, int'(bus.DIV0), 0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, int'(bus.DONE), 0);
  endtask

  initial begin
    int lat;
    int busy_ok;
    int done_cnt;

    rst       = 1'b1;
    bus.START = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", q_val(), 0);
    check("rst_r", r_val(), 0);
    check("rst_busy", int'(bus.BUSY), 0);
    check("rst_done", int'(bus.DONE), 0);
    check("rst_div0", int'(bus.DIV0), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run("pp", 100, 7, 14, 2);
    run("np", -100, 7, -14, -2);
    run("pn", 100, -7, -14, 2);
    run("nn", -100, -7, 14, -2);
    run("min_m1", -128, -1, 128, 0);
    run("min_min", -128, -128, 1, 0);
    run("max_min", 127, -128, 0, 127);
    run("min_p1", -128, 1, -128, 0);
    run("zero_dvd", 0, 5, 0, 0);
    run("small_neg", -7, 2, -3, -1);

`ifdef W_SEQ_DIVIDER_DIV0_EN
    start_op(5, 0);
    wait_done(lat, busy_ok);
    check("div0_lat", lat, 1);
    check("div0_flag", int'(bus.DIV0), 1);
    check("div0_q", q_val(), 0);
    check("div0_r", r_val(), 0);
    @(posedge clk);
    #1;
    check("div0_done_pulse", int'(bus.DONE), 0);
    run("after_div0", 6, 3, 2, 0);
`else
    start_op(5, 0);
    wait_done(lat, busy_ok);
    check("bzero_lat", lat, M + 1);
    check("bzero_div0", int'(bus.DIV0), 0);
    @(posedge clk);
    #1;
    run("after_bzero", 6, 3, 2, 0);
`endif

    // Back-to-back: START held during the DONE cycle, stray START mid-CALC.
    start_op(100, 7);
    wait_done(lat, busy_ok);
    check("b2b_first_lat", lat, M + 1);
    check("b2b_first_q", q_val(), 14);
    bus.A     = 8'd50;
    bus.B     = 8'd5;
    bus.START = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_accept_busy", int'(bus.BUSY), 1);
    check("b2b_accept_done", int'(bus.DONE), 0);
    lat = 0;
    while (bus.DONE !== 1'b1 && lat < 40) begin
      bus.START = (lat == 3) ? 1'b1 : 1'b0;
      bus.A     = 8'd99;
      bus.B     = 8'd3;
      @(posedge clk);
      #1;
      lat++;
    end
    bus.START = 1'b0;
    check("b2b_second_lat", lat, M + 1);
    check("b2b_second_q", q_val(), 10);
    check("b2b_second_r", r_val(), 0);
    done_cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.DONE === 1'b1 || bus.BUSY === 1'b1) done_cnt++;
    end
    check("no_queue", done_cnt, 0);
    check("hold_q", q_val(), 10);

    // Asynchronous reset in the middle of CALC.
    start_op(100, 7);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(bus.BUSY), 0);
    check("mid_rst_done", int'(bus.DONE), 0);
    check("mid_rst_q", q_val(), 0);
    check("mid_rst_r", r_val(), 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run("after_rst", 9, 2, 4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
